// File: rtl/csr_access_driver_pkg.sv
// Shared types for the CSR access driver: CSR op encoding, queued command
// record and the issue FSM states.
package csr_access_driver_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef struct packed {
    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        check;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mask;
    logic        exp_illegal;
  } csr_drv_cmd_t;

  localparam int unsigned CmdWidth = $bits(csr_drv_cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } csr_drv_state_e;

endpackage

// File: rtl/csr_access_driver_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a registered ready flag.
module csr_drv_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, rptr_q, wptr_d, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             ready_q;
  logic             push, pop;

  assign push    = push_i & ready_q;
  assign empty_o = (wptr_q == rptr_q);
  assign pop     = pop_i & ~empty_o;
  assign ready_o = ready_q;
  assign data_o  = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AddrW{1'b0}}, push};
    rptr_d = rptr_q + {{AddrW{1'b0}}, pop};
  end

  // ready is held low through reset and tracks next-cycle fullness
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= !((wptr_d[AddrW] != rptr_d[AddrW]) &&
                   (wptr_d[AddrW-1:0] == rptr_d[AddrW-1:0]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/csr_access_driver.sv
// CSR access initiator: queues commands, issues each as a one-cycle access,
// checks the response and keeps saturating statistics.
module csr_access_driver #(
  parameter int unsigned CmdDepth = 4,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [11:0]         cmd_addr_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic                cmd_check_i,
  input  logic [31:0]         cmd_exp_rdata_i,
  input  logic [31:0]         cmd_exp_mask_i,
  input  logic                cmd_exp_illegal_i,
  output logic                csr_access_o,
  output logic [11:0]         csr_addr_o,
  output logic [31:0]         csr_wdata_o,
  output logic [1:0]          csr_op_o,
  output logic                csr_op_en_o,
  input  logic [31:0]         csr_rdata_i,
  input  logic                csr_illegal_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [31:0]         resp_rdata_o,
  output logic                resp_illegal_o,
  output logic                resp_mismatch_o,
  output logic                fail_o,
  output logic [CntWidth-1:0] issued_cnt_o,
  output logic [CntWidth-1:0] mismatch_cnt_o,
  output logic [CntWidth-1:0] illegal_cnt_o
);

  import csr_access_driver_pkg::*;

  csr_drv_state_e      state_q, state_d;
  csr_drv_cmd_t        cmd_in, fifo_cmd, cmd_q;
  logic [CmdWidth-1:0] fifo_dout;
  logic                fifo_empty, pop, mismatch;
  logic [31:0]         resp_rdata_q;
  logic                resp_illegal_q, resp_mismatch_q, fail_q;
  logic [CntWidth-1:0] issued_q, mism_q, illeg_q;

  always_comb begin
    cmd_in             = '0;
    cmd_in.op          = csr_op_e'(cmd_op_i);
    cmd_in.addr        = cmd_addr_i;
    cmd_in.wdata       = cmd_wdata_i;
    cmd_in.check       = cmd_check_i;
    cmd_in.exp_rdata   = cmd_exp_rdata_i;
    cmd_in.exp_mask    = cmd_exp_mask_i;
    cmd_in.exp_illegal = cmd_exp_illegal_i;
  end

  csr_drv_fifo #(
    .Width(CmdWidth),
    .Depth(CmdDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (cmd_valid_i),
    .data_i (cmd_in),
    .ready_o(cmd_ready_o),
    .pop_i  (pop),
    .data_o (fifo_dout),
    .empty_o(fifo_empty)
  );

  assign fifo_cmd = csr_drv_cmd_t'(fifo_dout);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The illegal-flag compare is unconditional; check only gates the data compare.
  always_comb begin
    mismatch = (cmd_q.check && (((csr_rdata_i ^ cmd_q.exp_rdata) & cmd_q.exp_mask) != '0)) ||
               (csr_illegal_i != cmd_q.exp_illegal);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      cmd_q           <= '0;
      resp_rdata_q    <= '0;
      resp_illegal_q  <= 1'b0;
      resp_mismatch_q <= 1'b0;
      fail_q          <= 1'b0;
      issued_q        <= '0;
      mism_q          <= '0;
      illeg_q         <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= fifo_cmd;
      if (state_q == ST_ISSUE) begin
        resp_rdata_q    <= csr_rdata_i;
        resp_illegal_q  <= csr_illegal_i;
        resp_mismatch_q <= mismatch;
        fail_q          <= fail_q | mismatch;
        if (issued_q != '1) issued_q <= issued_q + CntWidth'(1);
        if (mismatch && (mism_q != '1)) mism_q <= mism_q + CntWidth'(1);
        if (csr_illegal_i && (illeg_q != '1)) illeg_q <= illeg_q + CntWidth'(1);
      end
    end
  end

  assign csr_access_o    = (state_q == ST_ISSUE);
  assign csr_op_en_o     = (state_q == ST_ISSUE);
  assign csr_addr_o      = cmd_q.addr;
  assign csr_wdata_o     = cmd_q.wdata;
  assign csr_op_o        = cmd_q.op;
  assign resp_valid_o    = (state_q == ST_RESP);
  assign resp_rdata_o    = resp_rdata_q;
  assign resp_illegal_o  = resp_illegal_q;
  assign resp_mismatch_o = resp_mismatch_q;
  assign fail_o          = fail_q;
  assign issued_cnt_o    = issued_q;
  assign mismatch_cnt_o  = mism_q;
  assign illegal_cnt_o   = illeg_q;

endmodule
